// File: rtl/cpu_mem_responder_if.sv
// CPU-side request/response bus of the memory responder.
// The master drives the request; the slave answers with busy, ready, rdata and err.
interface cpu_mem_responder_if;
   logic        req;
   logic        wr_en;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic        busy;
   logic        ready;
   logic [15:0] rdata;
   logic        err;

   modport master (
      output req, wr_en, addr, wdata,
      input  busy, ready, rdata, err
   );

   modport slave (
      input  req, wr_en, addr, wdata,
      output busy, ready, rdata, err
   );
endinterface

// File: rtl/cpu_mem_responder.sv
// Single-port 16-bit word memory answering CPU loads/stores after a fixed number
// of wait states; out-of-range addresses complete with err and leave memory untouched.
module cpu_mem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic            clk,
   input logic            rst,
   cpu_mem_responder_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        cap_wr;
   logic [7:0]  cap_addr;
   logic [15:0] cap_wdata;
   logic        accept;
   logic        in_range;
   logic [AW-1:0] mem_idx;

   logic [15:0] mem [0:DEPTH-1];

   assign accept   = (state == S_IDLE) && bus.req;
   assign in_range = int'(cap_addr) < DEPTH;
   assign mem_idx  = cap_addr[AW-1:0];

   // NOTE: combinational blocks use blocking '=' and assign every output a
   // default first, so no path can leave a latch behind.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (bus.req) begin
               if (WAIT_CYCLES > 0) begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WAIT_LOAD;
               end else begin
                  state_nxt = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) state_nxt = S_RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so every register sees the
   // pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         cap_wr    <= 1'b0;
         cap_addr  <= 8'd0;
         cap_wdata <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            cap_wr    <= bus.wr_en;
            cap_addr  <= bus.addr;
            cap_wdata <= bus.wdata;
         end
      end
   end

   // NOTE: the memory array has no reset; its contents survive rst and power up
   // undefined. An abort is safe because rst forces the state out of RESP.
   always_ff @(posedge clk) begin
      if (state == S_RESP && cap_wr && in_range)
         mem[mem_idx] <= cap_wdata;
   end

   // All outputs decode from the state register, so rst clears them at once.
   assign bus.busy  = (state != S_IDLE);
   assign bus.ready = (state == S_RESP);
   assign bus.err   = (state == S_RESP) && !in_range;
   assign bus.rdata = ((state == S_RESP) && !cap_wr && in_range) ? mem[mem_idx] : 16'd0;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: three instances cover the default build,
// a 128-word build and a zero-wait-state build, all sharing clk/rst.
module tb_cpu_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  addr = 8'd0;
   logic [15:0] wdata = 16'd0;
   int          sel = 0;

   int tests = 0;
   int fails = 0;

   logic        o_busy, o_ready, o_err;
   logic [15:0] o_rdata;

   always #5 clk = ~clk;

   cpu_mem_responder_if if_a ();
   cpu_mem_responder_if if_b ();
   cpu_mem_responder_if if_c ();

   assign if_a.req   = req && (sel == 0);
   assign if_b.req   = req && (sel == 1);
   assign if_c.req   = req && (sel == 2);
   assign if_a.wr_en = wr_en;
   assign if_b.wr_en = wr_en;
   assign if_c.wr_en = wr_en;
   assign if_a.addr  = addr;
   assign if_b.addr  = addr;
   assign if_c.addr  = addr;
   assign if_a.wdata = wdata;
   assign if_b.wdata = wdata;
   assign if_c.wdata = wdata;

   cpu_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   cpu_mem_responder #(.DEPTH(128), .WAIT_CYCLES(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
   cpu_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

   always_comb begin
      o_busy  = if_a.busy;
      o_ready = if_a.ready;
      o_err   = if_a.err;
      o_rdata = if_a.rdata;
      if (sel == 1) begin
         o_busy  = if_b.busy;
         o_ready = if_b.ready;
         o_err   = if_b.err;
         o_rdata = if_b.rdata;
      end else if (sel == 2) begin
         o_busy  = if_c.busy;
         o_ready = if_c.ready;
         o_err   = if_c.err;
         o_rdata = if_c.rdata;
      end
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".busy"},  {15'd0, o_busy},  16'd0);
      check({tag, ".ready"}, {15'd0, o_ready}, 16'd0);
      check({tag, ".err"},   {15'd0, o_err},   16'd0);
      check({tag, ".rdata"}, o_rdata,          16'd0);
   endtask

   // Called at a negedge with the selected DUT idle; returns at a negedge, idle again.
   task automatic run_req(input string tag, input logic wr, input logic [7:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rd,
                          input logic exp_err, input int n_wait);
      req = 1'b1; wr_en = wr; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; wr_en = 1'b0; addr = 8'd0; wdata = 16'd0;
      for (int i = 0; i < n_wait; i++) begin
         check({tag, ".wait_busy"},  {15'd0, o_busy},  16'd1);
         check({tag, ".wait_ready"}, {15'd0, o_ready}, 16'd0);
         @(negedge clk);
      end
      check({tag, ".resp_busy"},  {15'd0, o_busy},  16'd1);
      check({tag, ".resp_ready"}, {15'd0, o_ready}, 16'd1);
      check({tag, ".resp_err"},   {15'd0, o_err},   {15'd0, exp_err});
      check({tag, ".resp_rdata"}, o_rdata,          exp_rd);
      @(negedge clk);
      check_idle({tag, ".after"});
   endtask

   initial begin
      // Reset state
      #3;
      check_idle("reset_a");
      sel = 2;
      #1 check_idle("reset_c");
      sel = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Background contents
      run_req("pre_a3",  1'b1, 8'h03, 16'h00AA, 16'h0000, 1'b0, 2);
      run_req("pre_a7",  1'b1, 8'h07, 16'h5555, 16'h0000, 1'b0, 2);

      // Store then load back, two wait states
      run_req("st_a5",   1'b1, 8'h05, 16'hBEEF, 16'h0000, 1'b0, 2);
      run_req("ld_a5",   1'b0, 8'h05, 16'h0000, 16'hBEEF, 1'b0, 2);
      run_req("ld_a3",   1'b0, 8'h03, 16'h0000, 16'h00AA, 1'b0, 2);

      // 128-word build: out-of-range and last valid word
      sel = 1;
      run_req("pre_b10", 1'b1, 8'h10, 16'h1111, 16'h0000, 1'b0, 2);
      run_req("st_b90",  1'b1, 8'h90, 16'hDEAD, 16'h0000, 1'b1, 2);
      run_req("ld_b90",  1'b0, 8'h90, 16'h0000, 16'h0000, 1'b1, 2);
      run_req("ld_b10",  1'b0, 8'h10, 16'h0000, 16'h1111, 1'b0, 2);
      run_req("st_b80",  1'b1, 8'h80, 16'h0BAD, 16'h0000, 1'b1, 2);
      run_req("st_b7f",  1'b1, 8'h7F, 16'h7F7F, 16'h0000, 1'b0, 2);
      run_req("ld_b7f",  1'b0, 8'h7F, 16'h0000, 16'h7F7F, 1'b0, 2);
      run_req("ld_b10b", 1'b0, 8'h10, 16'h0000, 16'h1111, 1'b0, 2);

      // Zero wait states: single-cycle latency and back-to-back issue
      sel = 2;
      run_req("st_c0",   1'b1, 8'h00, 16'h0C0C, 16'h0000, 1'b0, 0);
      run_req("ld_c0",   1'b0, 8'h00, 16'h0000, 16'h0C0C, 1'b0, 0);
      req = 1'b1; wr_en = 1'b0; addr = 8'h00;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("held_c.ready%0d", i), {15'd0, o_ready}, (i % 2 == 0) ? 16'd1 : 16'd0);
         check($sformatf("held_c.rdata%0d", i), o_rdata, (i % 2 == 0) ? 16'h0C0C : 16'h0000);
      end
      req = 1'b0;
      @(negedge clk);
      check_idle("held_c.end");

      // Reset during WAIT aborts a store
      sel = 0;
      req = 1'b1; wr_en = 1'b1; addr = 8'h07; wdata = 16'h1234;
      @(negedge clk);
      req = 1'b0; wr_en = 1'b0; addr = 8'h00; wdata = 16'h0000;
      check("abort.busy_pre", {15'd0, o_busy}, 16'd1);
      #2 rst = 1'b1;
      #1 check_idle("abort.async");
      req = 1'b1; wr_en = 1'b0; addr = 8'h07;
      @(negedge clk);
      check_idle("abort.req_in_rst");
      @(negedge clk);
      check_idle("abort.req_in_rst2");
      req = 1'b0; addr = 8'h00;
      rst = 1'b0;
      @(negedge clk);
      check_idle("abort.post");
      run_req("ld_a7",   1'b0, 8'h07, 16'h0000, 16'h5555, 1'b0, 2);

      // Inputs changing during WAIT are ignored
      req = 1'b1; wr_en = 1'b0; addr = 8'h03; wdata = 16'h0000;
      @(negedge clk);
      wr_en = 1'b1; wdata = 16'hFFFF;
      check("ign.busy0",  {15'd0, o_busy},  16'd1);
      check("ign.ready0", {15'd0, o_ready}, 16'd0);
      @(negedge clk);
      addr = 8'h05; wdata = 16'h9999;
      check("ign.busy1",  {15'd0, o_busy},  16'd1);
      @(negedge clk);
      req = 1'b0; wr_en = 1'b0; addr = 8'h00; wdata = 16'h0000;
      check("ign.ready",  {15'd0, o_ready}, 16'd1);
      check("ign.err",    {15'd0, o_err},   16'd0);
      check("ign.rdata",  o_rdata,          16'h00AA);
      @(negedge clk);
      check_idle("ign.after");
      run_req("ld_a3b",  1'b0, 8'h03, 16'h0000, 16'h00AA, 1'b0, 2);
      run_req("ld_a5b",  1'b0, 8'h05, 16'h0000, 16'hBEEF, 1'b0, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
